// File: rtl/jelly_fixed_float_mul_arbiter.sv
// Round-robin arbiter that shares one float x fixed multiplier among several requesters.
// Issued requests carry the port id in the low bits of the user field.
// Results are routed back to the port named by that id.
// Per-port outstanding counters cap how many results each port can have in flight.
module jelly_fixed_float_mul_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ID_WIDTH        = $clog2(NUM_PORTS),
  parameter int USER_WIDTH      = 0,
  parameter int USER_BITS       = (USER_WIDTH > 0) ? USER_WIDTH : 1,
  parameter int FLOAT_WIDTH     = 23,
  parameter int S_FIXED_WIDTH   = 24,
  parameter int M_FIXED_WIDTH   = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cke,

  input  logic [NUM_PORTS*USER_BITS-1:0]     s_user,
  input  logic [NUM_PORTS*FLOAT_WIDTH-1:0]   s_float,
  input  logic [NUM_PORTS*S_FIXED_WIDTH-1:0] s_fixed,
  input  logic [NUM_PORTS-1:0]               s_valid,
  output logic [NUM_PORTS-1:0]               s_ready,

  output logic [NUM_PORTS*USER_BITS-1:0]     m_user,
  output logic [NUM_PORTS*M_FIXED_WIDTH-1:0] m_fixed,
  output logic [NUM_PORTS-1:0]               m_valid,
  input  logic [NUM_PORTS-1:0]               m_ready,

  output logic [USER_BITS+ID_WIDTH-1:0]      mul_s_user,
  output logic [FLOAT_WIDTH-1:0]             mul_s_float,
  output logic [S_FIXED_WIDTH-1:0]           mul_s_fixed,
  output logic                               mul_s_valid,
  input  logic                               mul_s_ready,

  input  logic [USER_BITS+ID_WIDTH-1:0]      mul_m_user,
  input  logic [M_FIXED_WIDTH-1:0]           mul_m_fixed,
  input  logic                               mul_m_valid,
  output logic                               mul_m_ready,

  output logic [NUM_PORTS*CNT_WIDTH-1:0]     outstanding,
  output logic                               busy
);

  logic [CNT_WIDTH-1:0]          cnt_q [NUM_PORTS];
  logic [ID_WIDTH-1:0]           last_grant_q;
  logic [ID_WIDTH-1:0]           winner;
  logic [ID_WIDTH-1:0]           cand;
  logic [NUM_PORTS-1:0]          eligible;
  logic                          found;
  logic                          slot_free;
  logic                          issue;
  logic [NUM_PORTS-1:0]          s_hs;
  logic [NUM_PORTS-1:0]          m_hs;
  logic [ID_WIDTH:0]             ret_id;
  logic                          ret_id_ok;

  logic                          slot_valid_q;
  logic [USER_BITS+ID_WIDTH-1:0] slot_user_q;
  logic [FLOAT_WIDTH-1:0]        slot_float_q;
  logic [S_FIXED_WIDTH-1:0]      slot_fixed_q;

  assign slot_free   = !slot_valid_q || mul_s_ready;
  assign mul_s_valid = slot_valid_q;
  assign mul_s_user  = slot_user_q;
  assign mul_s_float = slot_float_q;
  assign mul_s_fixed = slot_fixed_q;

  // Round-robin search starting one past the last grant.
  always_comb begin
    found = 1'b0;
    winner = '0;
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = s_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = ID_WIDTH'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
    issue = found && cke && slot_free;
    s_ready = '0;
    if (issue) s_ready[winner] = 1'b1;
    s_hs = s_ready & s_valid;
  end

  // Return routing: the low id bits of the returned tag select the destination port.
  always_comb begin
    ret_id = {1'b0, mul_m_user[ID_WIDTH-1:0]};
    ret_id_ok = ret_id < (ID_WIDTH + 1)'(NUM_PORTS);
    for (int i = 0; i < NUM_PORTS; i++) begin
      m_valid[i] = mul_m_valid && cke && (ret_id == (ID_WIDTH + 1)'(i));
    end
    // Unknown ids are swallowed so a bad tag cannot wedge the multiplier.
    mul_m_ready = cke && (ret_id_ok ? m_ready[mul_m_user[ID_WIDTH-1:0]] : 1'b1);
    m_hs = m_valid & m_ready;
    m_user = {NUM_PORTS{mul_m_user[USER_BITS+ID_WIDTH-1:ID_WIDTH]}};
    m_fixed = {NUM_PORTS{mul_m_fixed}};
  end

  // Pack counters and derive busy.
  always_comb begin
    outstanding = '0;
    busy = slot_valid_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      busy = busy || (cnt_q[i] != '0);
    end
  end

  // Issue slot and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 1'b0;
      slot_user_q  <= '0;
      slot_float_q <= '0;
      slot_fixed_q <= '0;
      last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
    end else if (cke && slot_free) begin
      slot_valid_q <= issue;
      if (issue) begin
        slot_user_q  <= {s_user[winner*USER_BITS +: USER_BITS], winner};
        slot_float_q <= s_float[winner*FLOAT_WIDTH +: FLOAT_WIDTH];
        slot_fixed_q <= s_fixed[winner*S_FIXED_WIDTH +: S_FIXED_WIDTH];
        last_grant_q <= winner;
      end
    end
  end

  // Outstanding counters; a simultaneous issue and return on one port cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (cke) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (s_hs[i] && !m_hs[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (m_hs[i] && !s_hs[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // Protocol checks: returns with no outstanding request, and tags naming no port.
  always_ff @(posedge clk) begin
    if (reset_n && cke) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        assert (!(m_hs[i] && cnt_q[i] == '0))
          else $error("return on port %0d with zero outstanding", i);
      end
      assert (!(mul_m_valid && !ret_id_ok))
        else $error("returned id %0d out of range", ret_id);
    end
  end

endmodule

// File: tb/tb_jelly_fixed_float_mul_arbiter.sv
// Directed bench for jelly_fixed_float_mul_arbiter with default parameters (4 ports).
module tb_jelly_fixed_float_mul_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cke;
  logic [3:0]  s_user;
  logic [91:0] s_float;
  logic [95:0] s_fixed;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [3:0]  m_user;
  logic [63:0] m_fixed;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [2:0]  mul_s_user;
  logic [22:0] mul_s_float;
  logic [23:0] mul_s_fixed;
  logic        mul_s_valid;
  logic        mul_s_ready;
  logic [2:0]  mul_m_user;
  logic [15:0] mul_m_fixed;
  logic        mul_m_valid;
  logic        mul_m_ready;
  logic [15:0] outstanding;
  logic        busy;

  int n_assert;
  int n_fail;

  logic [3:0]  usr;
  logic [22:0] fl [4];
  logic [23:0] fx [4];
  logic [1:0]  g;
  logic [3:0]  oh;

  jelly_fixed_float_mul_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .s_user      (s_user),
    .s_float     (s_float),
    .s_fixed     (s_fixed),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_user      (m_user),
    .m_fixed     (m_fixed),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .mul_s_user  (mul_s_user),
    .mul_s_float (mul_s_float),
    .mul_s_fixed (mul_s_fixed),
    .mul_s_valid (mul_s_valid),
    .mul_s_ready (mul_s_ready),
    .mul_m_user  (mul_m_user),
    .mul_m_fixed (mul_m_fixed),
    .mul_m_valid (mul_m_valid),
    .mul_m_ready (mul_m_ready),
    .outstanding (outstanding),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cke = 1'b1;
    s_valid = '0;
    m_ready = '0;
    mul_s_ready = 1'b1;
    mul_m_valid = 1'b0;
    mul_m_user = '0;
    #1;
    tick();
    reset_n = 1'b1;
  endtask

  // Expected issued tag {user bit of port, port id}.
  function automatic logic [2:0] exp_user(input logic [1:0] p);
    return {usr[p], p};
  endfunction

  task automatic check_slot(input string tag, input logic [1:0] p);
    check({tag, "_valid"}, 64'(mul_s_valid), 64'(1'b1));
    check({tag, "_user"}, 64'(mul_s_user), 64'(exp_user(p)));
    check({tag, "_float"}, 64'(mul_s_float), 64'(fl[p]));
    check({tag, "_fixed"}, 64'(mul_s_fixed), 64'(fx[p]));
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    usr = 4'b1010;
    fl[0] = 23'h100011; fl[1] = 23'h2a0022; fl[2] = 23'h3b0033; fl[3] = 23'h4c0044;
    fx[0] = 24'h800001; fx[1] = 24'h123456; fx[2] = 24'hfedcba; fx[3] = 24'h0f0f0f;
    s_user = usr;
    for (int i = 0; i < 4; i++) begin
      s_float[i*23 +: 23] = fl[i];
      s_fixed[i*24 +: 24] = fx[i];
    end
    reset_n = 1'b0;
    cke = 1'b1;
    s_valid = '0;
    m_ready = '0;
    mul_s_ready = 1'b0;
    mul_m_user = '0;
    mul_m_fixed = '0;
    mul_m_valid = 1'b0;
    #2;

    // Reset state
    check("rst_mul_s_valid", 64'(mul_s_valid), 64'(1'b0));
    check("rst_mul_s_user", 64'(mul_s_user), 64'(3'b0));
    check("rst_mul_s_float", 64'(mul_s_float), 64'(23'b0));
    check("rst_mul_s_fixed", 64'(mul_s_fixed), 64'(24'b0));
    check("rst_outstanding", 64'(outstanding), 64'(16'h0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_s_ready", 64'(s_ready), 64'(4'b0));
    check("rst_m_valid", 64'(m_valid), 64'(4'b0));
    check("rst_mul_m_ready", 64'(mul_m_ready), 64'(1'b0));
    tick();
    reset_n = 1'b1;

    // All ports requesting: grants rotate 0,1,2,3,0,1
    s_valid = 4'hf;
    mul_s_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g = 2'(i % 4);
      oh = 4'b0001 << g;
      #1;
      check("rr_s_ready", 64'(s_ready), 64'(oh));
      tick();
      check_slot("rr_slot", g);
    end
    check("rr_outstanding", 64'(outstanding), 64'(16'h1122));
    check("rr_busy", 64'(busy), 64'(1'b1));

    // Return to port 2 blocked by its consumer, then released
    s_valid = '0;
    mul_m_valid = 1'b1;
    mul_m_user = 3'b110;
    mul_m_fixed = 16'hbeef;
    m_ready = 4'b0000;
    #1;
    check("hol_m_valid", 64'(m_valid), 64'(4'b0100));
    check("hol_mul_m_ready", 64'(mul_m_ready), 64'(1'b0));
    check("hol_m_fixed", 64'(m_fixed), 64'({4{16'hbeef}}));
    check("hol_m_user", 64'(m_user), 64'(4'hf));
    tick();
    tick();
    check("hol_outstanding_held", 64'(outstanding), 64'(16'h1122));
    check("hol_slot_drained", 64'(mul_s_valid), 64'(1'b0));
    check("hol_m_valid_held", 64'(m_valid), 64'(4'b0100));
    m_ready = 4'b0100;
    #1;
    check("hol_mul_m_ready_up", 64'(mul_m_ready), 64'(1'b1));
    tick();
    mul_m_valid = 1'b0;
    m_ready = '0;
    #1;
    check("hol_outstanding_dec", 64'(outstanding), 64'(16'h1022));

    // Port 2 alone saturates at 8 outstanding
    do_reset();
    s_valid = 4'b0100;
    for (int i = 0; i < 8; i++) tick();
    #1;
    check("max_s_ready", 64'(s_ready), 64'(4'b0));
    check("max_outstanding", 64'(outstanding), 64'(16'h0800));
    tick();
    check("max_slot_drained", 64'(mul_s_valid), 64'(1'b0));
    check("max_busy", 64'(busy), 64'(1'b1));
    mul_m_valid = 1'b1;
    mul_m_user = 3'b010;
    m_ready = 4'b0100;
    #1;
    check("max_ret_ready", 64'(mul_m_ready), 64'(1'b1));
    check("max_s_ready_still0", 64'(s_ready), 64'(4'b0));
    tick();
    mul_m_valid = 1'b0;
    m_ready = '0;
    #1;
    check("max_after_ret", 64'(outstanding), 64'(16'h0700));
    check("max_regrant", 64'(s_ready), 64'(4'b0100));
    tick();
    check("max_refill", 64'(outstanding), 64'(16'h0800));
    check_slot("max_slot", 2'd2);

    // Port 1 increment and decrement in the same cycle
    do_reset();
    s_valid = 4'b0010;
    for (int i = 0; i < 3; i++) tick();
    check("incdec_pre", 64'(outstanding), 64'(16'h0030));
    mul_m_valid = 1'b1;
    mul_m_user = 3'b001;
    m_ready = 4'b0010;
    #1;
    check("incdec_s_ready", 64'(s_ready), 64'(4'b0010));
    check("incdec_m_valid", 64'(m_valid), 64'(4'b0010));
    tick();
    check("incdec_outstanding", 64'(outstanding), 64'(16'h0030));
    mul_m_valid = 1'b0;
    m_ready = '0;
    s_valid = '0;

    // Multiplier stall: slot holds, no grants, pointer stays
    do_reset();
    s_valid = 4'hf;
    tick();
    mul_s_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_s_ready", 64'(s_ready), 64'(4'b0));
      tick();
      check_slot("stall_slot", 2'd0);
    end
    mul_s_ready = 1'b1;
    #1;
    check("stall_next_grant", 64'(s_ready), 64'(4'b0010));
    tick();
    check_slot("stall_after", 2'd1);
    check("stall_outstanding", 64'(outstanding), 64'(16'h0011));

    // Clock enable low freezes everything, then asynchronous reset
    cke = 1'b0;
    mul_m_valid = 1'b1;
    mul_m_user = 3'b000;
    m_ready = 4'hf;
    #1;
    check("cke_s_ready", 64'(s_ready), 64'(4'b0));
    check("cke_m_valid", 64'(m_valid), 64'(4'b0));
    check("cke_mul_m_ready", 64'(mul_m_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cke_outstanding", 64'(outstanding), 64'(16'h0011));
      check_slot("cke_slot", 2'd1);
    end
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_outstanding", 64'(outstanding), 64'(16'h0));
    check("arst_mul_s_valid", 64'(mul_s_valid), 64'(1'b0));
    check("arst_busy", 64'(busy), 64'(1'b0));
    cke = 1'b1;
    mul_m_valid = 1'b0;
    m_ready = '0;
    tick();
    reset_n = 1'b1;
    #1;
    check("arst_first_grant", 64'(s_ready), 64'(4'b0001));
    tick();
    check_slot("arst_slot", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jelly_fixed_float_mul_arbiter.md
# jelly_fixed_float_mul_arbiter

Round-robin scheduler that shares one float×fixed multiplier pipeline among `NUM_PORTS` requesters. Each requester presents a float/fixed operand pair on its own valid/ready channel. The arbiter issues the winning operands into the multiplier with the port ID appended to the user field, then routes each result back to the originating port. Per-port outstanding counters bound how many results each port has in flight, so one stalled consumer cannot monopolise the pipeline.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requesters (2..16).
- `ID_WIDTH`, `$clog2(NUM_PORTS)`, width of the port tag.
- `USER_WIDTH`, 0, per-request sideband; `USER_BITS = max(USER_WIDTH,1)`.
- `FLOAT_WIDTH`, 23, operand float width (sign+exp+frac).
- `S_FIXED_WIDTH`, 24, operand fixed width.
- `M_FIXED_WIDTH`, 16, result fixed width.
- `MAX_OUTSTANDING`, 8, in-flight results allowed per port (1..255).
- `CNT_WIDTH`, `$clog2(MAX_OUTSTANDING+1)`, width of the outstanding counter.

Ports:
- `clk  in  1`  clock; all logic is on the rising edge.
- `reset_n  in  1`  asynchronous, active-low reset.
- `cke  in  1`  clock enable; low freezes all state.
- `s_user  in  NUM_PORTS*USER_BITS`  per-port sideband, packed with port 0 in the LSBs.
- `s_float  in  NUM_PORTS*FLOAT_WIDTH`  per-port float operand.
- `s_fixed  in  NUM_PORTS*S_FIXED_WIDTH`  per-port signed fixed operand.
- `s_valid  in  NUM_PORTS`  request valid.
- `s_ready  out  NUM_PORTS`  request accepted; one-hot or zero.
- `m_user  out  NUM_PORTS*USER_BITS`  returned sideband; all slices driven by the same bus.
- `m_fixed  out  NUM_PORTS*M_FIXED_WIDTH`  result; all slices driven by the same bus.
- `m_valid  out  NUM_PORTS`  result valid; one-hot or zero.
- `m_ready  in  NUM_PORTS`  result consumed.
- `mul_s_user  out  USER_BITS+ID_WIDTH`  issued user field as `{user, id}`.
- `mul_s_float  out  FLOAT_WIDTH`  issued float operand.
- `mul_s_fixed  out  S_FIXED_WIDTH`  issued fixed operand.
- `mul_s_valid  out  1`  issue valid.
- `mul_s_ready  in  1`  multiplier accepts.
- `mul_m_user  in  USER_BITS+ID_WIDTH`  returned tag from the multiplier.
- `mul_m_fixed  in  M_FIXED_WIDTH`  multiplier result.
- `mul_m_valid  in  1`  multiplier result valid.
- `mul_m_ready  out  1`  backpressure to the multiplier.
- `outstanding  out  NUM_PORTS*CNT_WIDTH`  per-port in-flight count.
- `busy  out  1`  OR of: `mul_s_valid`, any nonzero count.

## Operation
- **Issue register:** a single registered slot drives `mul_s_*`. It is free when `!mul_s_valid || mul_s_ready`.
- **Eligibility:** port i is eligible when `s_valid[i] && outstanding[i] < MAX_OUTSTANDING`.
- **Arbitration:**
  - Combinational round-robin. Search starts at `last_grant+1` and wraps modulo `NUM_PORTS`.
  - The first eligible port wins, but only while `cke` is high and the slot is free.
  - `s_ready[winner]=1`. The handshake loads the slot and sets `last_grant=winner`.
  - With no eligible port, `last_grant` is unchanged.
- **Tagging:** `mul_s_user = {s_user[winner], winner}`.
- **Counter update:**
  - Increment `outstanding[i]` on the `s` handshake of port i.
  - Decrement on the `m` handshake of port i.
  - If both occur in the same cycle for the same port, the count is unchanged.
  - Counts never wrap: eligibility prevents overflow. A decrement at 0 is a protocol error and must be asserted in simulation.
- **Return routing:** `id = mul_m_user[ID_WIDTH-1:0]`.
  - `m_valid[id] = mul_m_valid & cke`.
  - `mul_m_ready = m_ready[id] & cke`.
  - `m_user` and `m_fixed` are broadcast to all slices; `m_user` carries the upper bits of `mul_m_user`.
  - A returned id ≥ `NUM_PORTS` is dropped with `mul_m_ready=1` and must be asserted in simulation.
  - Results stay in order per port and globally, because the multiplier is in-order. A stalled port blocks the return path (head-of-line blocking); the counters limit issue depth.
- **`cke` low:** `s_ready=0`, `mul_m_ready=0`, `m_valid=0`, and no state changes. `mul_s_valid` holds its value.

## Timing
- **Reset values** (asynchronous, while `reset_n=0`):
  - `mul_s_valid=0` and `mul_s_*` data = 0.
  - All `outstanding=0`, `busy=0`.
  - `last_grant=NUM_PORTS-1`, so port 0 has first priority.
  - `s_ready`, `m_valid` and `mul_m_ready` are 0 because they derive from reset state and inputs.
- **Latency:** an `s` handshake in cycle N gives `mul_s_valid=1` in cycle N+1.
- **Throughput:** one issue per cycle when `mul_s_ready` is held high.
- **Return path:** combinational, zero added latency.
- **Handshakes:** `s_ready` may depend on `s_valid`. Data is captured on `valid&ready`. `mul_s_*` stay stable while `mul_s_valid && !mul_s_ready`.
- **Simultaneous events in one cycle:** an issue, a return to another port, and a counter increment/decrement on separate ports are all legal.
- **Reset mid-operation:** in-flight results already in the multiplier are discarded at the system level; the arbiter restarts from the reset state.

## Test plan
- Reset, then hold `s_valid=4'b1111` with `mul_s_ready=1`: grants go 0,1,2,3,0… on consecutive cycles, and `mul_s_user` low bits match the grant sequence.
- Only port 2 valid: after `MAX_OUTSTANDING=8` issues with no returns, `s_ready[2]=0` and `outstanding[2]=8`. One `m` handshake on port 2 brings the count to 7, and the next cycle grants again.
- Increment and decrement on port 1 in the same cycle: `outstanding[1]` is unchanged, e.g. it stays at 3.
- `mul_s_ready=0` for 5 cycles with a pending issue: `mul_s_*` are stable, `s_ready=0`, and `last_grant` does not advance.
- Return with tag 2 while `m_ready[2]=0`: `m_valid=4'b0100` and `mul_m_ready=0` until `m_ready[2]` rises, then a one-cycle handshake.
- `cke=0` for 3 cycles mid-stream, then `reset_n` pulsed low asynchronously: all counters read 0, `mul_s_valid=0`, and the next grant goes to port 0.
